// File: rtl/muacm_arb_pkg.sv
// Shared types and helpers for the muACM packet arbiters: FSM state encoding,
// the maximum supported requester count and the round-robin pick function.
package muacm_arb_pkg;

    localparam int ARB_N_MAX = 8;
    localparam int ARB_PTR_W = 3;

    typedef enum logic {
        ST_IDLE,
        ST_LOCK
    } arb_state_t;

    // Index of the first set bit in valid[] searching from ptr+1 upward,
    // wrapping modulo n. Returns ptr when nothing is valid.
    function automatic int rr_pick(input int n,
                                   input logic [ARB_PTR_W-1:0] ptr,
                                   input logic [ARB_N_MAX-1:0] valid);
        int cand;
        rr_pick = int'(ptr);
        // Walk from the farthest candidate back so the nearest one overwrites last.
        for (int k = ARB_N_MAX; k >= 1; k--) begin
            if (k <= n) begin
                cand = (int'(ptr) + k) % n;
                if (valid[cand[2:0]]) begin
                    rr_pick = cand;
                end
            end
        end
    endfunction

endpackage

// File: rtl/muacm_rr_pick.sv
// Combinational rotating priority encoder: picks the first asserted request
// after the round-robin pointer. Shared by the IN arbiter and the OUT demux.
module muacm_rr_pick #(
    parameter  int N  = 2,
    localparam int PW = $clog2(N)
) (
    input  logic [PW-1:0] ptr_i,
    input  logic [N-1:0]  req_i,
    output logic [PW-1:0] sel_o,
    output logic          any_o
);
    import muacm_arb_pkg::*;

    assign sel_o = PW'(rr_pick(N, ARB_PTR_W'(ptr_i), ARB_N_MAX'(req_i)));
    assign any_o = |req_i;

endmodule

// File: rtl/muacm_in_arb.sv
// Packet-level round-robin arbiter for the muACM IN byte pipe.
// Optional grant-revocation on owner stall: define MUACM_ARB_TIMEOUT_EN.
module muacm_in_arb #(
    parameter int N             = 2,
    parameter int FLUSH_ON_LAST = 1,
    parameter int TIMEOUT       = 255
) (
    input  logic           clk_usb,
    input  logic           rst_usb,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    output logic [7:0]     in_data,
    output logic           in_last,
    output logic           in_valid,
    input  logic           in_ready,
    output logic           in_flush_now,
    output logic           in_flush_time,
    output logic [N-1:0]   grant,
    output logic           busy
);
    import muacm_arb_pkg::*;

    localparam int PW = $clog2(N);

    if (N < 2 || N > ARB_N_MAX) begin : g_bad_n
        $error("muacm_in_arb: N out of range");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("muacm_in_arb: TIMEOUT out of range");
    end

    arb_state_t         state_q, state_d;
    logic [N-1:0]       grant_q, grant_d;
    logic [PW-1:0]      sel_q, sel_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic               flush_q, flush_d;
    logic [N-1:0][7:0]  req_bytes;
    logic [PW-1:0]      pick_sel;
    logic               pick_any;
    logic               timeout_hit;

    assign req_bytes = req_data;

    muacm_rr_pick #(.N(N)) u_pick (
        .ptr_i (ptr_q),
        .req_i (req_valid),
        .sel_o (pick_sel),
        .any_o (pick_any)
    );

`ifdef MUACM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] stall_q, stall_d;

    // Counts consecutive owner-idle cycles; the TIMEOUT-th one releases the grant.
    always_comb begin
        stall_d     = '0;
        timeout_hit = 1'b0;
        if (state_q == ST_LOCK && !req_valid[sel_q]) begin
            if (stall_q == CW'(TIMEOUT - 1)) begin
                timeout_hit = 1'b1;
            end else begin
                stall_d = stall_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_usb or posedge rst_usb) begin
        if (rst_usb) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets its default first so no path through the
        // case below leaves one unassigned and infers a latch.
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        flush_d   = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        req_ready = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d           = ST_LOCK;
                    sel_d             = pick_sel;
                    ptr_d             = pick_sel;
                    grant_d           = '0;
                    grant_d[pick_sel] = 1'b1;
                end
            end
            ST_LOCK: begin
                in_data          = req_bytes[sel_q];
                in_last          = req_last[sel_q];
                in_valid         = req_valid[sel_q];
                req_ready[sel_q] = in_ready;
                if (req_valid[sel_q] && in_ready && req_last[sel_q]) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    flush_d = (FLUSH_ON_LAST != 0);
                end else if (timeout_hit) begin
                    // Partial packet stays as sent; the flush pushes it to the host.
                    state_d = ST_IDLE;
                    grant_d = '0;
                    flush_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_usb or posedge rst_usb) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_usb) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= PW'(N - 1);
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            flush_q <= flush_d;
        end
    end

    assign grant         = grant_q;
    assign busy          = (state_q == ST_LOCK);
    assign in_flush_now  = flush_q;
    assign in_flush_time = 1'b1;

endmodule

// File: tb/tb_muacm_in_arb.sv
// Self-checking bench for muacm_in_arb: scoreboarded two-requester instance
// plus a table-driven four-requester instance with flush-on-last disabled.
module tb_muacm_in_arb;

    logic clk_usb = 1'b0;
    logic rst_usb = 1'b1;
    always #5 clk_usb = ~clk_usb;

    // Instance A: N=2, flush on last, TIMEOUT=8
    logic [15:0] a_req_data  = '0;
    logic [1:0]  a_req_last  = '0;
    logic [1:0]  a_req_valid = '0;
    logic [1:0]  a_req_ready;
    logic [7:0]  a_in_data;
    logic        a_in_last, a_in_valid, a_flush, a_ftime, a_busy;
    logic        a_in_ready = 1'b1;
    logic [1:0]  a_grant;

    // Instance B: N=4, no flush on last
    logic [31:0] b_req_data  = '0;
    logic [3:0]  b_req_last  = '0;
    logic [3:0]  b_req_valid = '0;
    logic [3:0]  b_req_ready;
    logic [7:0]  b_in_data;
    logic        b_in_last, b_in_valid, b_flush, b_ftime, b_busy;
    logic        b_in_ready = 1'b0;
    logic [3:0]  b_grant;

    muacm_in_arb #(.N(2), .FLUSH_ON_LAST(1), .TIMEOUT(8)) dut_a (
        .clk_usb(clk_usb), .rst_usb(rst_usb),
        .req_data(a_req_data), .req_last(a_req_last), .req_valid(a_req_valid),
        .req_ready(a_req_ready), .in_data(a_in_data), .in_last(a_in_last),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_flush_now(a_flush),
        .in_flush_time(a_ftime), .grant(a_grant), .busy(a_busy)
    );

    muacm_in_arb #(.N(4), .FLUSH_ON_LAST(0), .TIMEOUT(255)) dut_b (
        .clk_usb(clk_usb), .rst_usb(rst_usb),
        .req_data(b_req_data), .req_last(b_req_last), .req_valid(b_req_valid),
        .req_ready(b_req_ready), .in_data(b_in_data), .in_last(b_in_last),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_flush_now(b_flush),
        .in_flush_time(b_ftime), .grant(b_grant), .busy(b_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int         r;
        logic       last;
        logic [7:0] data;
    } beat_t;

    beat_t      exp_q[$];
    logic [8:0] pend0[$];
    logic [8:0] pend1[$];
    logic [1:0] acc = '0;
    int         rdy_mode = 0;
    logic       rdy_tog = 1'b0;
    bit         flush_chk = 1'b1;
    int         flush_cnt = 0;
    int         beats1 = 0;

    // ---------------- monitor / scoreboard for instance A ----------------
    bit    prev_last = 1'b0, prev2_last = 1'b0, pend_t1 = 1'b0, new_pend;
    beat_t got;

    always @(negedge clk_usb) begin
        if (rst_usb) begin
            acc        = '0;
            prev_last  = 1'b0;
            prev2_last = 1'b0;
            pend_t1    = 1'b0;
        end else begin
            acc = a_req_valid & a_req_ready;
            check("req_ready_owner", 32'(a_req_ready), 32'(a_grant & {2{a_in_ready}}));
            check("busy_vs_grant", 32'(a_busy), 32'(|a_grant));
            if (flush_chk) check("flush_pulse", 32'(a_flush), 32'(prev_last));
            if (a_flush) flush_cnt++;
            if (prev_last) begin
                check("idle_after_last_grant", 32'(a_grant), 0);
                check("idle_after_last_valid", 32'(a_in_valid), 0);
            end
            if (prev2_last) check("regrant_t2", 32'(|a_grant), 32'(pend_t1));
            new_pend   = prev_last && (|a_req_valid);
            prev2_last = prev_last;
            pend_t1    = new_pend;
            prev_last  = a_in_valid && a_in_ready && a_in_last;
            if (a_in_valid && a_in_ready) begin
                if (a_grant == 2'b10) beats1++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {24'h0, a_in_data}, 32'hFFFF_FFFF);
                end else begin
                    got = exp_q.pop_front();
                    check("beat_owner", 32'(a_grant), 32'(1) << got.r);
                    check("beat_data", 32'(a_in_data), 32'(got.data));
                    check("beat_last", 32'(a_in_last), 32'(got.last));
                end
            end
        end
    end

    // ---------------- producer model for instance A ----------------
    task automatic drive_reqs();
        a_req_valid[0]  = (pend0.size() != 0);
        a_req_data[7:0] = (pend0.size() != 0) ? pend0[0][7:0] : 8'h00;
        a_req_last[0]   = (pend0.size() != 0) ? pend0[0][8] : 1'b0;
        a_req_valid[1]   = (pend1.size() != 0);
        a_req_data[15:8] = (pend1.size() != 0) ? pend1[0][7:0] : 8'h00;
        a_req_last[1]    = (pend1.size() != 0) ? pend1[0][8] : 1'b0;
    endtask

    task automatic step();
        @(posedge clk_usb);
        #1;
        if (acc[0] && pend0.size() != 0) void'(pend0.pop_front());
        if (acc[1] && pend1.size() != 0) void'(pend1.pop_front());
        drive_reqs();
        case (rdy_mode)
            0:       a_in_ready = 1'b1;
            1:       begin rdy_tog = ~rdy_tog; a_in_ready = rdy_tog; end
            default: a_in_ready = 1'b0;
        endcase
    endtask

    task automatic load(input int r, input int len, input logic [7:0] base, input bit with_last);
        logic [8:0] b;
        for (int i = 0; i < len; i++) begin
            b = {(with_last && i == len - 1), base + 8'(i)};
            if (r == 0) pend0.push_back(b);
            else        pend1.push_back(b);
        end
        drive_reqs();
    endtask

    task automatic push_exp(input int r, input int len, input logic [7:0] base, input bit with_last);
        beat_t e;
        for (int i = 0; i < len; i++) begin
            e.r    = r;
            e.last = with_last && (i == len - 1);
            e.data = base + 8'(i);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_pkt(input int r, input int len, input logic [7:0] base);
        push_exp(r, len, base, 1'b1);
        load(r, len, base, 1'b1);
    endtask

    task automatic drain(input string name, input int budget);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            step();
            i++;
        end
        check(name, 32'(exp_q.size()), 0);
    endtask

    // ---------------- table for instance B ----------------
    typedef struct {
        logic [3:0] valid;
        logic       in_ready;
        logic [3:0] grant;
        logic       in_valid;
        logic [7:0] data;
        logic [3:0] ready;
    } vec_t;

    vec_t vt[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int snap;

        vt[0]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000};
        vt[1]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 8'hA0, 4'b0001};
        vt[2]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000};
        vt[3]  = '{4'hF, 1'b0, 4'b0010, 1'b1, 8'hA1, 4'b0000};
        vt[4]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 8'hA1, 4'b0010};
        vt[5]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000};
        vt[6]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 8'hA2, 4'b0100};
        vt[7]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000};
        vt[8]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 8'hA3, 4'b1000};
        vt[9]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000};
        vt[10] = '{4'hF, 1'b1, 4'b0001, 1'b1, 8'hA0, 4'b0001};
        vt[11] = '{4'hF, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000};

        // Reset state
        repeat (2) @(posedge clk_usb);
        #1;
        check("rst_grant", 32'(a_grant), 0);
        check("rst_busy", 32'(a_busy), 0);
        check("rst_in_valid", 32'(a_in_valid), 0);
        check("rst_req_ready", 32'(a_req_ready), 0);
        check("rst_flush", 32'(a_flush), 0);
        check("flush_time", 32'(a_ftime), 1);
        check("rst_grant_b", 32'(b_grant), 0);
        #2 rst_usb = 1'b0;
        step();

        // Two simultaneous 3-byte packets: req0 first, then req1
        send_pkt(0, 3, 8'h10);
        send_pkt(1, 3, 8'h20);
        #1;
        check("idle_latency_grant", 32'(a_grant), 0);
        step();
        check("first_grant", 32'(a_grant), 32'b01);
        drain("drain_two_pkts", 40);
        repeat (3) step();

        // req1 4-byte packet with in_ready toggling; req0 waits behind it
        beats1   = 0;
        rdy_mode = 1;
        send_pkt(1, 4, 8'h30);
        step();
        check("req1_owner", 32'(a_grant), 32'b10);
        send_pkt(0, 2, 8'h40);
        drain("drain_toggle", 60);
        check("req1_beats", 32'(beats1), 4);
        rdy_mode = 0;
        repeat (3) step();

        // Single 1-byte packet: exactly one flush pulse
        snap = flush_cnt;
        send_pkt(0, 1, 8'h55);
        drain("drain_flush", 20);
        repeat (3) step();
        check("flush_count", 32'(flush_cnt - snap), 1);

        // Owner drops valid mid-packet while req1 waits
        push_exp(0, 2, 8'h60, 1'b0);
        load(0, 2, 8'h60, 1'b0);
        drain("drain_partial", 20);
`ifdef MUACM_ARB_TIMEOUT_EN
        flush_chk = 1'b0;
        send_pkt(1, 2, 8'h70);
        repeat (7) step();
        check("hold_before_timeout", 32'(a_grant), 32'b01);
        step();
        check("timeout_release", 32'(a_grant), 0);
        check("timeout_flush", 32'(a_flush), 1);
        step();
        check("grant_after_timeout", 32'(a_grant), 32'b10);
        check("flush_after_timeout", 32'(a_flush), 0);
        flush_chk = 1'b1;
        drain("drain_after_timeout", 20);
`else
        load(1, 2, 8'h70, 1'b1);
        repeat (12) step();
        check("hold_through_gap", 32'(a_grant), 32'b01);
        send_pkt(0, 1, 8'h62);
        push_exp(1, 2, 8'h70, 1'b1);
        drain("drain_after_gap", 20);
`endif
        repeat (3) step();

        // Reset asserted mid-packet
        rdy_mode = 2;
        load(0, 3, 8'h80, 1'b1);
        repeat (2) step();
        check("pre_reset_owner", 32'(a_grant), 32'b01);
        #2 rst_usb = 1'b1;
        #1;
        check("midrst_grant", 32'(a_grant), 0);
        check("midrst_busy", 32'(a_busy), 0);
        check("midrst_in_valid", 32'(a_in_valid), 0);
        check("midrst_req_ready", 32'(a_req_ready), 0);
        check("midrst_flush", 32'(a_flush), 0);
        pend0.delete();
        pend1.delete();
        exp_q.delete();
        drive_reqs();
        repeat (2) step();
        #2 rst_usb = 1'b0;
        rdy_mode = 0;
        step();
        send_pkt(0, 1, 8'h90);
        send_pkt(1, 1, 8'h91);
        step();
        check("post_reset_prio", 32'(a_grant), 32'b01);
        drain("drain_post_reset", 20);
        repeat (3) step();

        // Instance B: four requesters streaming 1-byte packets
        b_req_last = 4'hF;
        b_req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int i = 0; i < 12; i++) begin
            b_req_valid = vt[i].valid;
            b_in_ready  = vt[i].in_ready;
            #1;
            check($sformatf("b_grant[%0d]", i), 32'(b_grant), 32'(vt[i].grant));
            check($sformatf("b_in_valid[%0d]", i), 32'(b_in_valid), 32'(vt[i].in_valid));
            check($sformatf("b_req_ready[%0d]", i), 32'(b_req_ready), 32'(vt[i].ready));
            check($sformatf("b_flush[%0d]", i), 32'(b_flush), 0);
            if (vt[i].in_valid) check($sformatf("b_in_data[%0d]", i), 32'(b_in_data), 32'(vt[i].data));
            @(posedge clk_usb);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
